// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, issues one imem read per cycle into a
// prefetch queue and hands {pc, instruction} to decode. Optional macro: FETCH_ALIGN_CHECK_EN.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_ce,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [63:0]     entry_q [DEPTH];
  logic [63:0]     entry_d;
  logic            pop;
  logic            issue;
  logic [63:0]     head;
`ifdef FETCH_ALIGN_CHECK_EN
  logic            fetch_err_q, fetch_err_d;
`endif

  assign inst_valid = (count_q != '0);
  assign head       = entry_q[rd_ptr_q];
  assign inst_pc    = head[63:32];
  assign inst_data  = head[31:0];
  assign imem_ce    = issue;
  assign imem_addr  = pc_q;
  assign entry_d    = {pc_q, imem_data};

  always_comb begin
    pop      = inst_valid & inst_ready & ~redirect_valid;
    issue    = (state_q == RUN) & ~rst & ~redirect_valid & ((count_q < DEPTH_C) | pop);
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fetch_err_d = fetch_err_q;
`endif
    if (redirect_valid) begin
      // Redirect flushes everything; the offered head is dropped even if accepted.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
`ifdef FETCH_ALIGN_CHECK_EN
      pc_d = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d     = HALT;
        fetch_err_d = 1'b1;
      end else begin
        state_d     = RUN;
        fetch_err_d = 1'b0;
      end
`else
      pc_d = redirect_pc & ~32'h3;
`endif
    end else begin
      if (issue) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        pc_d     = pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({issue, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage clears on reset so the head reads 0 until the first fetch lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else if (issue) begin
      entry_q[wr_ptr_q] <= entry_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= fetch_err_d;
    end
  end
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: a queue-level reference model predicts fetches,
// a monitor pops expected {pc, data} pairs on every accepted handshake.
module tb_inst_fetch_ctrl;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ce;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_err;

  inst_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_ce(imem_ce), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ 32'hA5A5_0000;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] mq [$];
  logic [63:0] sb [$];
  logic [31:0] mpc;
  bit          mhalt;
  bit          merr;
  bit          pop_e;
  bit          iss_e;
  logic [63:0] exp_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents, fetch PC and halt state evolve per cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_imem_ce", {31'b0, imem_ce}, 32'd0);
      check("rst_imem_addr", imem_addr, RESET_PC);
      check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
      mq.delete();
      sb.delete();
      mpc   = RESET_PC;
      mhalt = 1'b0;
      merr  = 1'b0;
    end else begin
      pop_e = (mq.size() != 0) && inst_ready && !redirect_valid;
      iss_e = !mhalt && !redirect_valid && ((mq.size() < DEPTH) || pop_e);
      check("imem_ce", {31'b0, imem_ce}, {31'b0, iss_e});
      check("imem_addr", imem_addr, mpc);
      check("inst_valid", {31'b0, inst_valid}, {31'b0, (mq.size() != 0)});
      check("fetch_err", {31'b0, fetch_err}, {31'b0, merr});
      if (redirect_valid) begin
        mq.delete();
        sb.delete();
`ifdef FETCH_ALIGN_CHECK_EN
        mpc   = redirect_pc;
        mhalt = (redirect_pc[1:0] != 2'b00);
        merr  = mhalt;
`else
        mpc = redirect_pc & ~32'h3;
`endif
      end else begin
        if (pop_e) void'(mq.pop_front());
        if (iss_e) begin
          mq.push_back({mpc, mpc ^ 32'hA5A5_0000});
          sb.push_back({mpc, mpc ^ 32'hA5A5_0000});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  // Monitor: every accepted head must match the oldest expected fetch.
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      check("head_expected", {31'b0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        exp_e = sb.pop_front();
        check("inst_pc", inst_pc, exp_e[63:32]);
        check("inst_data", inst_data, exp_e[31:0]);
      end
    end
  end

  task automatic step(input logic r, input logic rv, input logic [31:0] rpc);
    inst_ready     = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  int          thresh;
  logic [31:0] rnd;
  logic [31:0] rpc;

  initial begin
    rst            = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    repeat (8) step(1'b1, 1'b0, 32'h0);                    // stream from reset
    repeat (10) step(1'b0, 1'b0, 32'h0);                   // backpressure fills queue
    repeat (8) step(1'b1, 1'b0, 32'h0);
    repeat (6) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_00B4);                       // redirect with full queue
    repeat (5) step(1'b1, 1'b0, 32'h0);
    repeat (6) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);                               // issue+pop while full
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'hFFFF_FFF8);                       // pc wrap
    repeat (5) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0102);                       // misaligned redirect
    repeat (3) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0100);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0200);                       // back-to-back redirects
    step(1'b1, 1'b1, 32'h0000_0300);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    rst = 1'b1;                                            // asynchronous mid-run reset
    repeat (2) step(1'b1, 1'b0, 32'h0);
    rst = 1'b0;
    repeat (4) step(1'b1, 1'b0, 32'h0);

    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) thresh = $urandom_range(10, 100);
      rnd = $urandom;
      case ($urandom_range(0, 3))
        0:       rpc = rnd;
        1:       rpc = 32'hFFFF_FFF0 + {28'b0, rnd[3:2], 2'b00};
        default: rpc = {rnd[31:2], 2'b00};
      endcase
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        rst = 1'b0;
      end
      step($urandom_range(0, 99) < thresh, $urandom_range(0, 31) == 0, rpc);
    end

    step(1'b0, 1'b0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
